// File: rtl/alu_seq.sv
// alu_seq: valid/ready ALU with registered result and an iterative shift-add multiply on F=011
module alu_seq #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       F,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nxt, alu_y;
  logic [CW-1:0] cnt;
  logic accept, is_mul, mul_done;
  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = MUL_EN && (F == 3'b011);
  assign acc_nxt  = acc + (b_sh[0] ? a_sh : '0);
  assign mul_done = (state == MUL) && (cnt == CW'(WIDTH - 1));
  always_comb begin
    alu_y = '0;
    case (F)
      3'b000:  alu_y = A & B;
      3'b001:  alu_y = A | B;
      3'b010:  alu_y = A + B;
      3'b100:  alu_y = A & ~B;
      3'b101:  alu_y = A | ~B;
      3'b110:  alu_y = A - B;
      3'b111:  alu_y = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      default: alu_y = '0;
    endcase
  end
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = (accept && is_mul) ? MUL : IDLE;
    else state_nxt = mul_done ? IDLE : MUL;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // An accept always clears or replaces the current result, since in_ready implies it is free or being consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Y         <= '0;
      zero      <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else if (accept && !is_mul) begin
      Y         <= alu_y;
      zero      <= (alu_y == '0);
      out_valid <= 1'b1;
    end else if (accept) begin
      a_sh      <= A;
      b_sh      <= B;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else if (state == MUL) begin
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      acc  <= acc_nxt;
      cnt  <= cnt + CW'(1);
      if (mul_done) begin
        Y         <= acc_nxt;
        zero      <= (acc_nxt == '0);
        out_valid <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven vectors with a result scoreboard, plus multiply, backpressure and reset sequences
module tb_alu_seq;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, zero;
  logic [31:0] A = '0, B = '0, Y, exp_y = '0;
  logic [2:0]  F = '0;
  int n_vec = 0, n_err = 0, cyc = 0;
  logic [31:0] exp_q[$];
  int out_cyc[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
    logic [31:0] y;
  } vec_t;
  vec_t tv[12];

  alu_seq #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .F(F), .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Scoreboard: pop on consume, then push on accept (both take effect at the following edge)
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        out_cyc.push_back(cyc);
        if (exp_q.size() == 0) chk("unexpected_out", Y, 32'hx);
        else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("sb_y", Y, e);
          chk("sb_zero", 32'(zero), 32'(e == 0));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(exp_y);
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f, input logic [31:0] y);
    bit ok;
    A = a; B = b; F = f; exp_y = y; in_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic mul_chk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] y, input bit poke);
    int n;
    bit bad;
    send(a, b, 3'b011, y);
    A = 32'd1; B = 32'd2; F = 3'b010; exp_y = 32'd3; in_valid = poke;
    n = 0; bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) break;
      if (in_ready) bad = 1;
      n++;
    end
    chk("mul_latency", 32'(n), 32'd32);
    chk("mul_in_ready_low", 32'(bad), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, bad;
    tv[0]  = '{32'hFFFFFFFF, 32'h00000001, 3'b010, 32'h00000000};
    tv[1]  = '{32'h80000000, 32'h00000000, 3'b111, 32'h00000001};
    tv[2]  = '{32'h00000005, 32'hFFFFFFFF, 3'b111, 32'h00000000};
    tv[3]  = '{32'h0000F0F0, 32'h0000FF00, 3'b100, 32'h000000F0};
    tv[4]  = '{32'h0000F0F0, 32'h0000FF00, 3'b000, 32'h0000F000};
    tv[5]  = '{32'h0000F0F0, 32'h0000FF00, 3'b001, 32'h0000FFF0};
    tv[6]  = '{32'h00000001, 32'h0F0F0F0F, 3'b101, 32'hF0F0F0F1};
    tv[7]  = '{32'h00000003, 32'h00000005, 3'b110, 32'hFFFFFFFE};
    tv[8]  = '{32'h00000000, 32'h00000001, 3'b110, 32'hFFFFFFFF};
    tv[9]  = '{32'hFFFFFFFF, 32'h00000000, 3'b111, 32'h00000001};
    tv[10] = '{32'h7FFFFFFF, 32'h00000001, 3'b010, 32'h80000000};
    tv[11] = '{32'h7FFFFFFF, 32'h80000000, 3'b111, 32'h00000000};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", Y, 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    @(posedge clk); #1;

    send(32'hFFFFFFFF, 32'h1, 3'b010, 32'h0);
    chk("add_wrap_valid", 32'(out_valid), 32'd1);
    chk("add_wrap_y", Y, 32'h0);
    chk("add_wrap_zero", 32'(zero), 32'd1);
    drain();

    k = out_cyc.size();
    for (int i = 0; i < 12; i++) send(tv[i].a, tv[i].b, tv[i].f, tv[i].y);
    drain();
    chk("stream_count", 32'(out_cyc.size() - k), 32'd12);
    if (out_cyc.size() >= k + 12) chk("stream_consecutive", 32'(out_cyc[k + 11] - out_cyc[k]), 32'd11);

    mul_chk(32'h00012345, 32'h00001000, 32'h12345000, 1'b1);
    mul_chk(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    mul_chk(32'h00001234, 32'h00000000, 32'h00000000, 1'b0);
    drain();

    send(32'd10, 32'd20, 3'b010, 32'd30);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_y", Y, 32'd30);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h0F, 32'hF0, 3'b001, 32'hFF);
    chk("bp_next_y", Y, 32'hFF);
    repeat (2) @(negedge clk);
    chk("consume_valid_low", 32'(out_valid), 32'd0);
    chk("consume_y_hold", Y, 32'hFF);
    @(posedge clk); #1;

    send(32'd3, 32'd5, 3'b011, 32'd15);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midmul_rst_valid", 32'(out_valid), 32'd0);
    chk("midmul_rst_y", Y, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    chk("aborted_mul_silent", 32'(bad), 32'd0);
    @(posedge clk); #1;
    send(32'd3, 32'd4, 3'b010, 32'd7);
    chk("post_rst_add", Y, 32'd7);
    drain();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
